// File: rtl/ahf_sw_entry_port.sv
// Switch-entry receiver: synchronises and debounces the SW[4] strobe, packs SW[3:0] nibbles into words, queues them in a 2-deep FIFO.
// Optional macro AHF_SWIN_ECHO_EN adds echo_o = {nibble count, last captured nibble}.
module ahf_sw_entry_port #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int NIBBLES        = DATA_W / 4,
  localparam int CNT_W          = $clog2(NIBBLES + 1)
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic [4:0]        SW,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overflow_o,
  output logic [CNT_W-1:0]  nib_cnt_o
`ifdef AHF_SWIN_ECHO_EN
  ,
  output logic [7:0]        echo_o
`endif
);

  localparam int FLT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {IDLE, PRESSED} state_t;

  logic [4:0]        sw_p0, sw_p1;
  logic              db_p2;
  logic [FLT_W-1:0]  flt_cnt;
  state_t            state, state_nxt;
  logic              cap;
  logic              push;
  logic              pop;
  logic              accept;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_nxt;
  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;

  // Stage p0/p1: two-flop synchroniser for the asynchronous switches
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= SW;
      sw_p1 <= sw_p0;
    end
  end

  // Stage p2: debounce filter on the synchronised strobe
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      db_p2   <= 1'b0;
      flt_cnt <= '0;
    end else if (sw_p1[4] != db_p2) begin
      if (flt_cnt == FLT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_p2   <= ~db_p2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end else begin
      flt_cnt <= '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (db_p2) begin
          state_nxt = PRESSED;
          cap       = 1'b1;
        end
      end
      PRESSED: begin
        if (!db_p2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p3: nibble packing; the completing nibble is pushed straight into the FIFO
  assign word_nxt = {word_q[DATA_W-5:0], sw_p1[3:0]};
  assign push     = cap && (nib_cnt_o == CNT_W'(NIBBLES - 1));
  assign pop      = rd_en && valid_o;
  assign accept   = push && ((count != 2'd2) || pop);

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      word_q    <= '0;
      nib_cnt_o <= '0;
    end else if (cap) begin
      word_q    <= word_nxt;
      nib_cnt_o <= push ? '0 : nib_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      overflow_o <= 1'b0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, accept} - {1'b0, pop};
      // A dropped word outranks a simultaneous clear
      if (push && !accept) overflow_o <= 1'b1;
      else if (clr_ovf)    overflow_o <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (accept) mem[wr_ptr] <= word_nxt;
  end

  assign valid_o = (count != 2'd0);
  assign data_o  = valid_o ? mem[rd_ptr] : '0;

`ifdef AHF_SWIN_ECHO_EN
  logic [3:0] last_nib;

  always_ff @(posedge CLOCK_50) begin
    if (Reset)    last_nib <= 4'd0;
    else if (cap) last_nib <= sw_p1[3:0];
  end

  assign echo_o = {4'(nib_cnt_o), last_nib};
`endif

endmodule

// File: tb/tb_ahf_sw_entry_port.sv
// Scoreboard bench for ahf_sw_entry_port: word-level reference model feeds an expected-word queue, a monitor checks every pop.
`timescale 1ns/1ps
module tb_ahf_sw_entry_port;

  localparam int DW   = 8;
  localparam int DB   = 16;
  localparam int NIB  = DW / 4;
  localparam int LAT  = DB + 3;
  localparam int HOLD = 80;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic [4:0]    SW = '0;
  logic          rd_en = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          overflow_o;
  logic [1:0]    nib_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  int mdl_cnt = 0;
  int pw      = 0;
  int pc      = 0;
  bit ovf     = 0;
  int exp_q[$];

  ahf_sw_entry_port #(.DATA_W(DW), .DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50  (clk),
    .Reset     (Reset),
    .SW        (SW),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .overflow_o(overflow_o),
    .nib_cnt_o (nib_cnt_o)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected word
  always @(negedge clk) begin
    if (!Reset && rd_en && valid_o) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no word", data_o);
      end else begin
        check("pop_data", int'(data_o), exp_q.pop_front());
      end
    end
  end

  task automatic check_state(input string tag);
    check({tag, "_valid"},   int'(valid_o),    int'(mdl_cnt != 0));
    check({tag, "_data"},    int'(data_o),     (mdl_cnt != 0) ? exp_q[0] : 0);
    check({tag, "_ovf"},     int'(overflow_o), int'(ovf));
    check({tag, "_nib_cnt"}, int'(nib_cnt_o),  pc);
  endtask

  task automatic do_reset(input int cyc);
    Reset = 1'b1;
    repeat (cyc) @(posedge clk);
    #1;
    check("rst_data",    int'(data_o),     0);
    check("rst_valid",   int'(valid_o),    0);
    check("rst_ovf",     int'(overflow_o), 0);
    check("rst_nib_cnt", int'(nib_cnt_o),  0);
    Reset = 1'b0;
    mdl_cnt = 0; pw = 0; pc = 0; ovf = 0;
    exp_q.delete();
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    if (mdl_cnt > 0) mdl_cnt--;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic do_clr();
    clr_ovf = 1'b1;
    ovf = 0;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
  endtask

  // One full press/release of the strobe carrying nibble n
  task automatic press(input logic [3:0] n, input bit chk_lat, input bit rd_at_push);
    SW = {1'b1, n};
    for (int k = 1; k <= HOLD; k++) begin
      @(posedge clk); #1;
      if (rd_at_push && k == LAT - 1) rd_en = 1'b1;
      if (rd_at_push && k == LAT)     rd_en = 1'b0;
      if (chk_lat && k == LAT - 1) check("valid_before_push", int'(valid_o), 0);
      if (chk_lat && k == LAT)     check("valid_at_push",     int'(valid_o), 1);
      if (k > LAT) SW[3:0] = 4'($urandom);
    end
    if (rd_at_push && mdl_cnt > 0) mdl_cnt--;
    pw = (pw * 16 + int'(n)) % (1 << DW);
    pc++;
    if (pc == NIB) begin
      if (mdl_cnt < 2) begin
        exp_q.push_back(pw);
        mdl_cnt++;
      end else begin
        ovf = 1;
      end
      pc = 0;
      pw = 0;
    end
    check("nib_cnt_after_press", int'(nib_cnt_o), pc);
    SW = {1'b0, SW[3:0]};
    repeat (HOLD) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(15);

    press(4'hA, 0, 0);
    press(4'hE, 1, 0);
    check_state("ae");
    do_read();
    check_state("ae_drained");

    SW = {1'b1, 4'h3};
    repeat (10) @(posedge clk);
    SW = {1'b0, 4'h3};
    repeat (40) @(posedge clk);
    #1;
    check_state("glitch");

    press(4'h1, 0, 0); press(4'h2, 0, 0);
    press(4'h3, 0, 0); press(4'h4, 0, 0);
    press(4'h5, 0, 0); press(4'h6, 0, 0);
    check_state("ovf_full");
    do_read();
    check_state("ovf_pop1");
    do_read();
    check_state("ovf_pop2");
    do_read();
    check_state("empty_read");
    do_clr();
    check_state("ovf_clr");

    press(4'h1, 0, 0); press(4'h2, 0, 0);
    press(4'h3, 0, 0); press(4'h4, 0, 0);
    press(4'h5, 0, 0); press(4'h6, 0, 1);
    check_state("push_pop_full");
    do_read();
    check_state("push_pop_next");
    do_read();

    press(4'h7, 0, 0);
    do_reset(1);
    press(4'h9, 0, 0);
    press(4'hC, 0, 0);
    check_state("after_reset");
    do_read();

    for (int i = 0; i < 24; i++) begin
      press(4'($urandom), 0, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) do_read();
      if ($urandom_range(0, 5) == 0) do_clr();
      check_state("rand");
    end

    for (int i = 0; i < 3 && mdl_cnt > 0; i++) do_read();
    check("scoreboard_empty", exp_q.size(), 0);
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
